// File: rtl/uart_mem_loader.sv
// UART program loader: receives I/D/G commands over 8N1 serial and writes 32-bit
// words into the core's instruction or data memory while holding the core in reset.
module uart_mem_loader #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_write,
  output logic [31:0]           imem_data_in,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_enable,
  output logic [3:0]            dmem_byte_write,
  output logic [31:0]           dmem_data_in,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  error
);

  localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, WRITE} state_t;

  rx_state_t       rx_state, rx_state_next;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]   baud_cnt, baud_cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      rx_shift, rx_shift_next;
  logic            byte_valid, frame_err;

  state_t          state, state_next;
  logic            target_imem;
  logic [7:0]      addr_hi;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [15:0]     cnt16;
  logic [23:0]     word;
  logic [1:0]      byte_idx;

  // Synchronizer and receiver registers; the line idles high so reset to 1 to avoid a false start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      rx_shift <= rx_shift_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    baud_cnt_next = baud_cnt + 1'b1;
    bit_idx_next  = bit_idx;
    rx_shift_next = rx_shift;
    byte_valid    = 1'b0;
    frame_err     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        baud_cnt_next = '0;
        if (rx_prev && !rx_sync) rx_state_next = RX_START;
      end
      RX_START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt == DIV_LAST) begin
          baud_cnt_next = '0;
          rx_shift_next = {rx_sync, rx_shift[7:1]};
          bit_idx_next  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_cnt == DIV_LAST) begin
          baud_cnt_next = '0;
          rx_state_next = RX_IDLE;
          if (rx_sync) byte_valid = 1'b1;
          else         frame_err  = 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Strobes are decoded from the WRITE state so they can never fire outside it.
  always_comb begin
    state_next      = state;
    imem_write      = 1'b0;
    dmem_enable     = 1'b0;
    dmem_byte_write = 4'b0000;
    case (state)
      IDLE:    if (byte_valid && (rx_shift == 8'h49 || rx_shift == 8'h44)) state_next = ADDR_HI;
      ADDR_HI: if (byte_valid) state_next = ADDR_LO;
      ADDR_LO: if (byte_valid) state_next = CNT_HI;
      CNT_HI:  if (byte_valid) state_next = CNT_LO;
      CNT_LO:  if (byte_valid) state_next = ({cnt16[7:0], rx_shift} == 16'd0) ? IDLE : DATA;
      DATA:    if (byte_valid && byte_idx == 2'd3) state_next = WRITE;
      WRITE: begin
        imem_write      = target_imem;
        dmem_enable     = !target_imem;
        dmem_byte_write = {4{!target_imem}};
        state_next      = (cnt16 == 16'd1) ? IDLE : DATA;
      end
      default: state_next = IDLE;
    endcase
    if (frame_err && state != IDLE) state_next = IDLE;
  end

  assign busy = (state != IDLE);

  // Command datapath; memory outputs are loaded on the 4th data byte and held until the next write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_imem  <= 1'b0;
      addr_hi      <= '0;
      addr_reg     <= '0;
      cnt16        <= '0;
      word         <= '0;
      byte_idx     <= '0;
      core_reset   <= 1'b1;
      error        <= 1'b0;
      imem_addr    <= '0;
      imem_data_in <= '0;
      dmem_addr    <= '0;
      dmem_data_in <= '0;
    end else begin
      if (frame_err) error <= 1'b1;
      case (state)
        IDLE: begin
          if (byte_valid) begin
            case (rx_shift)
              8'h49:   begin target_imem <= 1'b1; core_reset <= 1'b1; end
              8'h44:   begin target_imem <= 1'b0; core_reset <= 1'b1; end
              8'h47:   core_reset <= 1'b0;
              default: error <= 1'b1;
            endcase
          end
        end
        ADDR_HI: if (byte_valid) addr_hi <= rx_shift;
        ADDR_LO: if (byte_valid) addr_reg <= ADDR_WIDTH'({addr_hi, rx_shift});
        CNT_HI:  if (byte_valid) cnt16 <= {8'h00, rx_shift};
        CNT_LO: begin
          if (byte_valid) begin
            cnt16    <= {cnt16[7:0], rx_shift};
            byte_idx <= '0;
          end
        end
        DATA: begin
          if (byte_valid) begin
            word     <= {word[15:0], rx_shift};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (target_imem) begin
                imem_addr    <= addr_reg;
                imem_data_in <= {word, rx_shift};
              end else begin
                dmem_addr    <= addr_reg;
                dmem_data_in <= {word, rx_shift};
              end
            end
          end
        end
        WRITE: begin
          addr_reg <= addr_reg + 1'b1;
          cnt16    <= cnt16 - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed testbench for uart_mem_loader: serial commands in, memory write strobes checked.
module tb_uart_mem_loader;

  logic        clk;
  logic        reset_n;
  logic        uart_rx;
  logic [11:0] imem_addr;
  logic        imem_write;
  logic [31:0] imem_data_in;
  logic [11:0] dmem_addr;
  logic        dmem_enable;
  logic [3:0]  dmem_byte_write;
  logic [31:0] dmem_data_in;
  logic        core_reset;
  logic        busy;
  logic        error;

  int checks;
  int failures;

  logic [11:0] imem_addr_q[$];
  logic [31:0] imem_data_q[$];
  logic [11:0] dmem_addr_q[$];
  logic [31:0] dmem_data_q[$];
  logic [3:0]  dmem_be_q[$];
  int          long_pulses;
  int          imem_run;
  int          dmem_run;

  uart_mem_loader #(
    .CLK_FREQ_HZ(1000000),
    .BAUD(100000),
    .ADDR_WIDTH(12)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .uart_rx(uart_rx),
    .imem_addr(imem_addr),
    .imem_write(imem_write),
    .imem_data_in(imem_data_in),
    .dmem_addr(dmem_addr),
    .dmem_enable(dmem_enable),
    .dmem_byte_write(dmem_byte_write),
    .dmem_data_in(dmem_data_in),
    .core_reset(core_reset),
    .busy(busy),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe and flag any that lasts longer than one cycle.
  always @(negedge clk) begin
    if (imem_write) begin
      imem_addr_q.push_back(imem_addr);
      imem_data_q.push_back(imem_data_in);
      imem_run++;
      if (imem_run > 1) long_pulses++;
    end else begin
      imem_run = 0;
    end
    if (dmem_enable) begin
      dmem_addr_q.push_back(dmem_addr);
      dmem_data_q.push_back(dmem_data_in);
      dmem_be_q.push_back(dmem_byte_write);
      dmem_run++;
      if (dmem_run > 1) long_pulses++;
    end else begin
      dmem_run = 0;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_logs();
    imem_addr_q.delete();
    imem_data_q.delete();
    dmem_addr_q.delete();
    dmem_data_q.delete();
    dmem_be_q.delete();
    long_pulses = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (core_reset !== 1'b1) begin failures++; $display("[TB] FAIL reset_core_reset actual=%0h required=1", core_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%0h required=0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error actual=%0h required=0", error); end
    checks++; if ({imem_write, dmem_enable, dmem_byte_write} !== 6'b0) begin failures++; $display("[TB] FAIL reset_strobes actual=%0h required=0", {imem_write, dmem_enable, dmem_byte_write}); end
    checks++; if ({imem_addr, dmem_addr, imem_data_in, dmem_data_in} !== 88'h0) begin failures++; $display("[TB] FAIL reset_addr_data actual=%0h required=0", {imem_addr, dmem_addr, imem_data_in, dmem_data_in}); end
    clear_logs();
    repeat (1000) @(negedge clk);
    checks++; if ({core_reset, busy, error} !== 3'b100) begin failures++; $display("[TB] FAIL idle_line_state actual=%b required=100", {core_reset, busy, error}); end
    checks++; if (imem_addr_q.size() + dmem_addr_q.size() != 0) begin failures++; $display("[TB] FAIL idle_line_writes actual=%0d required=0", imem_addr_q.size() + dmem_addr_q.size()); end
  endtask

  task automatic test_imem_load();
    logic [7:0] cmd[13];
    cmd = '{8'h49, 8'h00, 8'h10, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
    clear_logs();
    for (int i = 0; i < 13; i++) send_byte(cmd[i], 1'b1);
    checks++; if (imem_addr_q.size() != 2) begin failures++; $display("[TB] FAIL imem_write_count actual=%0d required=2", imem_addr_q.size()); end
    checks++; if (imem_addr_q[0] !== 12'h010 || imem_data_q[0] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL imem_first actual=%h/%h required=010/deadbeef", imem_addr_q[0], imem_data_q[0]); end
    checks++; if (imem_addr_q[1] !== 12'h011 || imem_data_q[1] !== 32'h00000013) begin failures++; $display("[TB] FAIL imem_second actual=%h/%h required=011/00000013", imem_addr_q[1], imem_data_q[1]); end
    checks++; if (long_pulses != 0) begin failures++; $display("[TB] FAIL imem_pulse_width actual=%0d required=0", long_pulses); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL imem_busy_after actual=%0h required=0", busy); end
    checks++; if (dmem_addr_q.size() != 0 || dmem_addr !== 12'h0 || dmem_data_in !== 32'h0) begin failures++; $display("[TB] FAIL imem_dmem_untouched actual=%0d/%h/%h required=0/000/00000000", dmem_addr_q.size(), dmem_addr, dmem_data_in); end
  endtask

  task automatic test_dmem_wrap();
    logic [7:0] cmd[13];
    cmd = '{8'h44, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
    clear_logs();
    for (int i = 0; i < 13; i++) send_byte(cmd[i], 1'b1);
    checks++; if (dmem_addr_q.size() != 2) begin failures++; $display("[TB] FAIL dmem_write_count actual=%0d required=2", dmem_addr_q.size()); end
    checks++; if (dmem_addr_q[0] !== 12'hFFF || dmem_data_q[0] !== 32'h11111111) begin failures++; $display("[TB] FAIL dmem_first actual=%h/%h required=fff/11111111", dmem_addr_q[0], dmem_data_q[0]); end
    checks++; if (dmem_addr_q[1] !== 12'h000 || dmem_data_q[1] !== 32'h22222222) begin failures++; $display("[TB] FAIL dmem_wrap actual=%h/%h required=000/22222222", dmem_addr_q[1], dmem_data_q[1]); end
    checks++; if (dmem_be_q[0] !== 4'hF || dmem_be_q[1] !== 4'hF) begin failures++; $display("[TB] FAIL dmem_byte_write actual=%h/%h required=f/f", dmem_be_q[0], dmem_be_q[1]); end
    checks++; if (imem_addr_q.size() != 0 || long_pulses != 0) begin failures++; $display("[TB] FAIL dmem_other_strobes actual=%0d/%0d required=0/0", imem_addr_q.size(), long_pulses); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL dmem_busy_after actual=%0h required=0", busy); end
  endtask

  task automatic test_go();
    clear_logs();
    send_byte(8'h47, 1'b1);
    checks++; if (core_reset !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL go_release actual=%b%b required=00", core_reset, busy); end
    send_byte(8'h49, 1'b1);
    checks++; if (core_reset !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL go_reassert actual=%b%b required=11", core_reset, busy); end
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
    checks++; if (busy !== 1'b0 || imem_addr_q.size() != 0) begin failures++; $display("[TB] FAIL zero_count actual=%0h/%0d required=0/0", busy, imem_addr_q.size()); end
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL go_no_error actual=%0h required=0", error); end
  endtask

  task automatic test_errors();
    clear_logs();
    send_byte(8'h5A, 1'b1);
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL bad_cmd actual=%b%b required=10", error, busy); end
    send_byte(8'h49, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL in_data_busy actual=%0h required=1", busy); end
    send_byte(8'h55, 1'b0);
    checks++; if (busy !== 1'b0 || error !== 1'b1) begin failures++; $display("[TB] FAIL frame_abort actual=%b%b required=01", busy, error); end
    checks++; if (imem_addr_q.size() != 0 || core_reset !== 1'b1) begin failures++; $display("[TB] FAIL frame_no_write actual=%0d/%0h required=0/1", imem_addr_q.size(), core_reset); end
  endtask

  task automatic test_glitch();
    apply_reset();
    clear_logs();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch actual=%b%b required=00", error, busy); end
    checks++; if (imem_addr_q.size() + dmem_addr_q.size() != 0) begin failures++; $display("[TB] FAIL glitch_writes actual=%0d required=0", imem_addr_q.size() + dmem_addr_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [7:0] cmd[11];
    cmd = '{8'h49, 8'h00, 8'h20, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    clear_logs();
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 11; i++) send_byte(cmd[i], 1'b1);
    checks++; if (busy !== 1'b1 || imem_addr !== 12'h020 || imem_data_in !== 32'h01020304 || error !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset actual=%0h/%h/%h/%0h required=1/020/01020304/1", busy, imem_addr, imem_data_in, error); end
    uart_rx = 1'b0;
    repeat (25) @(negedge clk);
    #2;
    reset_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || core_reset !== 1'b1 || error !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_ctrl actual=%b%b%b required=010", busy, core_reset, error); end
    checks++; if (imem_addr !== 12'h0 || imem_data_in !== 32'h0 || imem_write !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_imem actual=%h/%h/%0h required=000/00000000/0", imem_addr, imem_data_in, imem_write); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_logs();
    cmd = '{8'h44, 8'h00, 8'h05, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) send_byte(cmd[i], 1'b1);
    checks++; if (dmem_addr_q.size() != 1 || dmem_addr_q[0] !== 12'h005 || dmem_data_q[0] !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL post_reset_cmd actual=%0d/%h/%h required=1/005/cafef00d", dmem_addr_q.size(), dmem_addr_q[0], dmem_data_q[0]); end
    checks++; if (busy !== 1'b0 || error !== 1'b0 || imem_addr_q.size() != 0) begin failures++; $display("[TB] FAIL post_reset_state actual=%0h/%0h/%0d required=0/0/0", busy, error, imem_addr_q.size()); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    long_pulses = 0;
    imem_run    = 0;
    dmem_run    = 0;
    reset_n     = 1'b1;
    uart_rx     = 1'b1;
    test_reset();
    test_imem_load();
    test_dmem_wrap();
    test_go();
    test_errors();
    test_glitch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
